// File: rtl/reg_writeback_queue_pkg.sv
// Shared definitions for the register-file write-back path.
// Holds the default data/index widths of the 8x8 register file and the
// write-back entry type used by the EX/MEM stage register, the hazard unit
// and the write-back queue.
package reg_writeback_queue_pkg;

    localparam int WBQ_DATA_W = 8;
    localparam int WBQ_ADDR_W = 3;
    localparam int WBQ_DEPTH  = 2;

    // One pending register write: destination index plus result value.
    typedef struct packed {
        logic [WBQ_ADDR_W-1:0] reg_idx;
        logic [WBQ_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Age-priority match of one decode read address against the write-back queue.
// Scans the valid entries from oldest (head) to youngest; the youngest entry
// whose destination equals rd_reg supplies the forwarded value.
// Ports:
//   head      in   oldest-entry slot index
//   count     in   number of valid entries
//   reg_mem   in   destination index of every slot
//   data_mem  in   data of every slot
//   rd_reg    in   read address to look up
//   fwd_hit   out  some valid entry targets rd_reg
//   fwd_data  out  youngest matching value, 0 when no hit
module wbq_fwd_match
    import reg_writeback_queue_pkg::*;
#(
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W,
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic [PTR_W-1:0]              head,
    input  logic [CNT_W-1:0]              count,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  reg_mem,
    input  logic [DEPTH-1:0][DATA_W-1:0]  data_mem,
    input  logic [ADDR_W-1:0]             rd_reg,
    output logic                          fwd_hit,
    output logic [DATA_W-1:0]             fwd_data
);

    logic                hit_s;
    logic [DATA_W-1:0]   data_s;
    logic [PTR_W-1:0]    slot_s;

    // Oldest-to-youngest scan so a later (younger) match overrides an older one.
    always_comb begin
        hit_s  = 1'b0;
        data_s = {DATA_W{1'b0}};
        slot_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            // Power-of-two depth: the slot index wraps naturally in PTR_W bits.
            slot_s = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (reg_mem[slot_s] == rd_reg)) begin
                hit_s  = 1'b1;
                data_s = data_mem[slot_s];
            end else begin
                hit_s  = hit_s;
                data_s = data_s;
            end
        end
    end

    assign fwd_hit  = hit_s;
    assign fwd_data = data_s;

endmodule

// File: rtl/reg_writeback_queue.sv
// Write side of the 8x8 register file. Buffers execute/memory results in a
// small in-order queue, drains the head into the register-file write port
// whenever the port is granted, and forwards the youngest pending value for
// two decode read addresses.
// Ports:
//   Clk, Reset                     clock, synchronous active-high reset
//   wb_valid/wb_ready/wb_reg/wb_data   upstream result handshake
//   wr_grant                       write port available this cycle
//   RegWrite/Write_Reg_Num_1/Write_Data  register-file write port
//   rd_reg_1/2, fwd_hit_1/2, fwd_data_1/2  decode-stage bypass
//   pending                        current queue occupancy
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter int DATA_W = WBQ_DATA_W,
    parameter int ADDR_W = WBQ_ADDR_W,
    parameter int DEPTH  = WBQ_DEPTH
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [ADDR_W-1:0]          wb_reg,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       wr_grant,
    output logic                       RegWrite,
    output logic [ADDR_W-1:0]          Write_Reg_Num_1,
    output logic [DATA_W-1:0]          Write_Data,
    input  logic [ADDR_W-1:0]          rd_reg_1,
    input  logic [ADDR_W-1:0]          rd_reg_2,
    output logic                       fwd_hit_1,
    output logic [DATA_W-1:0]          fwd_data_1,
    output logic                       fwd_hit_2,
    output logic [DATA_W-1:0]          fwd_data_2,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]              head_r;
    logic [PTR_W-1:0]              tail_r;
    logic [CNT_W-1:0]              count_r;
    logic [DEPTH-1:0][ADDR_W-1:0]  reg_mem_r;
    logic [DEPTH-1:0][DATA_W-1:0]  data_mem_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;

    // Full/empty come from the occupancy count so pointer equality is never ambiguous.
    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Ready depends only on occupancy, never on this cycle's grant.
    assign wb_ready = !full_s;
    assign push_s   = wb_valid && !full_s;
    assign pop_s    = !empty_s && wr_grant;
    assign RegWrite = pop_s;
    assign pending  = count_r;

    // Present the head entry on the write port, zeros when nothing is queued.
    always_comb begin
        if (empty_s) begin
            Write_Reg_Num_1 = {ADDR_W{1'b0}};
            Write_Data      = {DATA_W{1'b0}};
        end else begin
            Write_Reg_Num_1 = reg_mem_r[head_r];
            Write_Data      = data_mem_r[head_r];
        end
    end

    // Control state: pointers and count, cleared by Reset (in-flight entries are dropped).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage: data is not reset, only the count decides which slots are live.
    always_ff @(posedge Clk) begin
        if (push_s && !Reset) begin
            reg_mem_r[tail_r]  <= wb_reg;
            data_mem_r[tail_r] <= wb_data;
        end else begin
            reg_mem_r  <= reg_mem_r;
            data_mem_r <= data_mem_r;
        end
    end

    wbq_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fwd_1 (
        .head     (head_r),
        .count    (count_r),
        .reg_mem  (reg_mem_r),
        .data_mem (data_mem_r),
        .rd_reg   (rd_reg_1),
        .fwd_hit  (fwd_hit_1),
        .fwd_data (fwd_data_1)
    );

    wbq_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fwd_2 (
        .head     (head_r),
        .count    (count_r),
        .reg_mem  (reg_mem_r),
        .data_mem (data_mem_r),
        .rd_reg   (rd_reg_2),
        .fwd_hit  (fwd_hit_2),
        .fwd_data (fwd_data_2)
    );

endmodule
